// File: rtl/hazard_scoreboard.sv
// Decode-stage issue gate: forwarding-aware RAW scoreboard plus counted control-flow shadow.
// Define HAZ_PERF_CNT_EN to add saturating stall/squash cycle counters.
module hazard_scoreboard #(
  parameter int unsigned REG_W     = 3,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned FWD       = 0,
  parameter int unsigned BR_SHADOW = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic             id_rs_used,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rt_used,
  input  logic             id_wr_en,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_is_load,
  input  logic             id_is_ctrl,
  input  logic             ex_redirect,
  output logic             stall,
  output logic             bubble,
  output logic             shadow_active
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [15:0]      stall_cycles,
  output logic [15:0]      squash_cycles
`endif
);

  localparam int unsigned CNT_W = 3;

  typedef enum logic {RUN, SHADOW} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DEPTH-1:0] v_q, v_d;
  logic [REG_W-1:0] rd_q [DEPTH];
  logic [REG_W-1:0] rd_d [DEPTH];
  logic             ld0_q, ld0_d;
  logic             raw;
  logic             stall_c, bubble_c, issue_c;

  // Only the youngest entry's load flag matters: with full bypass, only load-use stalls.
  always_comb begin
    raw = 1'b0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if ((FWD == 0) || ((k == 0) && ld0_q)) begin
        if (v_q[k] && ((id_rs_used && (rd_q[k] == id_rs)) ||
                       (id_rt_used && (rd_q[k] == id_rt)))) begin
          raw = 1'b1;
        end
      end
    end
  end

  // Issue decision and control-shadow sequencing; redirect overrides everything.
  always_comb begin
    stall_c  = 1'b0;
    bubble_c = 1'b0;
    state_d  = state_q;
    cnt_d    = cnt_q;
    if (ex_redirect) begin
      bubble_c = 1'b1;
      state_d  = RUN;
      cnt_d    = '0;
    end else begin
      case (state_q)
        RUN: begin
          if (id_valid && raw) begin
            stall_c  = 1'b1;
            bubble_c = 1'b1;
          end else if (id_valid && id_is_ctrl && (BR_SHADOW != 0)) begin
            state_d = SHADOW;
            cnt_d   = CNT_W'(BR_SHADOW);
          end
        end
        SHADOW: begin
          bubble_c = 1'b1;
          cnt_d    = cnt_q - CNT_W'(1);
          if (cnt_q <= CNT_W'(1)) begin
            state_d = RUN;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign issue_c = id_valid & ~stall_c & ~bubble_c;

  // Shadow pipeline: entry 0 captures the issuing instruction, older entries age by one.
  always_comb begin
    v_d[0]  = issue_c & id_wr_en;
    rd_d[0] = id_rd;
    ld0_d   = id_is_load;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      v_d[k]  = v_q[k-1];
      rd_d[k] = rd_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      v_q     <= '0;
      ld0_q   <= 1'b0;
      for (int unsigned k = 0; k < DEPTH; k++) rd_q[k] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      v_q     <= v_d;
      ld0_q   <= ld0_d;
      for (int unsigned k = 0; k < DEPTH; k++) rd_q[k] <= rd_d[k];
    end
  end

  // Outputs are forced low for the whole time reset is held.
  assign stall         = rst & stall_c;
  assign bubble        = rst & bubble_c;
  assign shadow_active = rst & (state_q == SHADOW);

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles  <= '0;
      squash_cycles <= '0;
    end else begin
      if (stall && (stall_cycles != 16'hFFFF)) stall_cycles <= stall_cycles + 16'd1;
      if (bubble && !stall && (squash_cycles != 16'hFFFF)) squash_cycles <= squash_cycles + 16'd1;
    end
  end
`endif

endmodule
